gda_edc_n8: RTL
===============

Name: gda_edc_n8

Overview:
- Sequential error-detection-and-correction (EDC) unit for the generic accuracy-configurable adder family.
- Accepts an operand pair and computes the approximate sum, using carry prediction limited to a window of P generate bits.
- Detects whether the prediction window dropped any real carry. If it did, the window is widened by P bits per cycle until the sum is exact.
- Sits behind the approximate datapath as its accuracy-recovery end. Reports the approximate sum, the exact sum, an error flag and the number of correction cycles used.

Parameters:
- W, 8, operand width in bits; result is W+1 bits.
- P, 4, base carry-prediction window depth in bits; also the window increment per correction cycle; 1 <= P <= W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands.
- in1  input  W  operand A.
- in2  input  W  operand B.
- approx_only  input  1  sampled with operands; 1 = skip correction.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res  output  W+1  final sum: exact, or approximate when approx_only=1.
- res_approx  output  W+1  sum computed with window depth P.
- err  output  1  approximate sum differed from exact sum.
- corr_cycles  output  clog2(W/P+1)  number of widening cycles performed.
- err_count  output  16  present only with GDA_ERR_CNT_EN.

Behaviour:
- Definitions:
  - g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
  - Windowed carry into bit i at depth d: OR over k = 1..min(d, i) of (g[i-k] & p[i-k+1] & ... & p[i-1]). Carry into bit 0 is 0.
  - sum[i] = p[i] ^ c_d[i]. Bit W = g[W-1] | (p[W-1] & c_d[W-1]).
  - Depth d >= W is exact.
- Error at depth d: any bit i in 1..W-1 where c_d[i] != c_W[i].
- Reset (asynchronous, rst_n=0):
  - State IDLE; in_ready=1; out_valid=0.
  - res, res_approx, corr_cycles and err_count are 0; err=0.
  - Any in-flight operation is discarded without output.
- FSM: IDLE, EVAL, DONE.
  - IDLE: in_ready=1. On in_valid & in_ready, register in1, in2 and approx_only; set d=P and corr_cycles=0; go to EVAL.
  - EVAL, first cycle: register res_approx (depth P) and err = error at depth P.
  - EVAL, each cycle: if approx_only=1, or there is no error at the current d, or d >= W, then res = sum at current d and go to DONE. Otherwise d = min(d+P, W), corr_cycles += 1, and stay in EVAL.
  - DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE; in_ready rises the following cycle (no same-cycle turnaround).
- Latency: operands accepted at edge T produce out_valid after edge T+2+corr_cycles.
  - Maximum corr_cycles is ceil(W/P)-1 (1 at defaults).
- in_ready=0 in EVAL and DONE; in_valid in those states is ignored, not queued.
- out_valid stays high until out_ready; it never drops without a handshake.
- err reflects the depth-P prediction even when approx_only=1. In that case corr_cycles=0 and res=res_approx.
- Operand registers are not sampled outside IDLE.

Optional Feature:
- Macro: GDA_ERR_CNT_EN.
- When defined:
  - err_count port exists.
  - 16-bit saturating counter incremented at the DONE handshake when err=1.
  - Holds at 0xFFFF; cleared only by reset.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-EVAL:
  - Accept 0xFF+0x01, then assert rst_n=0 in EVAL -> out_valid=0, in_ready=1, all outputs 0.
  - After release, 0x02+0x03 -> res=0x005, err=0.
- No-error path:
  - 0x0F+0x01 -> res=res_approx=0x010, err=0, corr_cycles=0, out_valid 2 cycles after accept.
  - 0xF0+0x10 -> res=0x100, err=0.
- Correction path:
  - 0xFF+0x01 -> res_approx=0x0E0, res=0x100, err=1, corr_cycles=1, out_valid 3 cycles after accept.
- approx_only=1 with 0xFF+0x01 -> res=0x0E0, res_approx=0x0E0, err=1, corr_cycles=0, latency 2.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with 0x80+0x80 pending -> out_valid and res=0x100 stable, in_ready=0.
  - A new in_valid presented meanwhile is not accepted.
  - Release -> one handshake; in_ready=1 on the next cycle.
- With GDA_ERR_CNT_EN:
  - Three operations 0xFF+0x01, 0x0F+0x01, 0x7F+0x01 -> err_count=2.
  - Preload via 65535 error operations -> stays 0xFFFF.

Source files
------------

// File: rtl/gda_edc_n8.sv
// rtl/gda_edc_n8.sv - windowed-carry adder with iterative error detection and correction
// Optional GDA_ERR_CNT_EN adds a 16-bit saturating err_count output.
module gda_edc_n8 #(
  parameter int W = 8,
  parameter int P = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in1,
  input  logic [W-1:0]                 in2,
  input  logic                         approx_only,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W:0]                   res,
  output logic [W:0]                   res_approx,
  output logic                         err,
  output logic [$clog2(W/P+1)-1:0]     corr_cycles
`ifdef GDA_ERR_CNT_EN
  ,
  output logic [15:0]                  err_count
`endif
);

  localparam int CW = $clog2(W/P+1);
  localparam int DW = $clog2(W+P+1);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            ao_q;
  logic            first_q;
  logic [DW-1:0]   d_q;

  // Sum whose carry into bit i only sees generate bits within d positions below i.
  function automatic logic [W:0] win_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int d);
    logic [W-1:0] c;
    logic [W-1:0] p;
    logic         run;
    p = a ^ b;
    c = '0;
    for (int i = 1; i < W; i++) begin
      run = 1'b1;
      for (int j = W - 2; j >= 0; j--) begin
        if (j < i) begin
          if (i - j <= d) c[i] = c[i] | (a[j] & b[j] & run);
          run = run & p[j];
        end
      end
    end
    return {(a[W-1] & b[W-1]) | (p[W-1] & c[W-1]), p ^ c};
  endfunction

  logic [W:0]    sum_base;
  logic [W:0]    sum_cur;
  logic [W:0]    sum_exact;
  logic          err_base;
  logic          err_cur;
  logic [DW-1:0] d_inc;
  logic [DW-1:0] d_next;

  // Equal low sums imply equal carries at every bit, so comparing sums detects a dropped carry.
  assign sum_base  = win_sum(a_q, b_q, P);
  assign sum_cur   = win_sum(a_q, b_q, int'(d_q));
  assign sum_exact = {1'b0, a_q} + {1'b0, b_q};
  assign err_base  = (sum_base != sum_exact);
  assign err_cur   = (sum_cur != sum_exact);
  assign d_inc     = d_q + DW'(P);
  assign d_next    = (d_inc >= DW'(W)) ? DW'(W) : d_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      res         <= '0;
      res_approx  <= '0;
      err         <= 1'b0;
      corr_cycles <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ao_q        <= 1'b0;
      first_q     <= 1'b0;
      d_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q         <= in1;
            b_q         <= in2;
            ao_q        <= approx_only;
            d_q         <= DW'(P);
            corr_cycles <= '0;
            first_q     <= 1'b1;
            in_ready    <= 1'b0;
            state       <= EVAL;
          end
        end
        EVAL: begin
          if (first_q) begin
            res_approx <= sum_base;
            err        <= err_base;
            first_q    <= 1'b0;
          end else if (ao_q || !err_cur || (d_q >= DW'(W))) begin
            res       <= sum_cur;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            d_q         <= d_next;
            corr_cycles <= corr_cycles + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GDA_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if ((state == DONE) && out_ready && err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
